// File: rtl/counter_ud_mod.sv
// counter_ud_mod -- up/down counter with programmable step, modulo-wrap or
// saturating bounds, boundary event pulses and a sticky overflow flag.
//
// Parameters
//   WIDTH    counter width in bits
//   MAX_VAL  terminal value; count range is 0..MAX_VAL (1..2**WIDTH-1)
//   STEP_W   step input width; 2**STEP_W-1 must not exceed MAX_VAL
//
// Ports
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   clr        in   synchronous clear (highest priority)
//   load_en    in   load count from load (clamped to MAX_VAL)
//   load       in   [WIDTH]  load value
//   en         in   count enable
//   down       in   1 = count down, 0 = count up
//   step       in   [STEP_W] step magnitude
//   sat_mode   in   1 = saturate at bounds, 0 = modulo wrap
//   count      out  [WIDTH]  registered count
//   rollover   out  registered pulse on an up-boundary crossing
//   underflow  out  registered pulse on a down-boundary crossing
//   ovf_sticky out  registered; set by any boundary event, cleared by clr/reset
//   at_max     out  combinational count == MAX_VAL
//   at_zero    out  combinational count == 0
//
// Optional feature (macro COUNTER_UD_MOD_CMP_EN):
//   cmp_val    in   [WIDTH]  compare value
//   cmp_hit    out  registered pulse when count changes to cmp_val

module counter_ud_mod #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1,
  parameter int unsigned STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load,
  input  logic              en,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
`ifdef COUNTER_UD_MOD_CMP_EN
  input  logic [WIDTH-1:0]  cmp_val,
  output logic              cmp_hit,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              rollover,
  output logic              underflow,
  output logic              ovf_sticky,
  output logic              at_max,
  output logic              at_zero
);

  // Parameter sanity checks at elaboration time.
  if (MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max
    $error("counter_ud_mod: MAX_VAL out of range 1..2**WIDTH-1");
  end
  if ((2 ** STEP_W) - 1 > MAX_VAL) begin : g_bad_step
    $error("counter_ud_mod: 2**STEP_W-1 must be <= MAX_VAL");
  end

  localparam int unsigned EW = WIDTH + 1;  // extended arithmetic width

  logic [EW-1:0]    max_ext;
  logic [EW-1:0]    cnt_ext;
  logic [EW-1:0]    step_ext;
  logic [EW-1:0]    load_ext;
  logic [EW-1:0]    sum_ext;

  logic [WIDTH-1:0] count_q,     count_d;
  logic             rollover_q,  rollover_d;
  logic             underflow_q, underflow_d;
  logic             sticky_q,    sticky_d;

  assign max_ext  = EW'(MAX_VAL);
  assign cnt_ext  = {1'b0, count_q};
  assign step_ext = EW'(step);
  assign load_ext = {1'b0, load};
  assign sum_ext  = cnt_ext + step_ext;

  always_comb begin
    count_d     = count_q;
    rollover_d  = 1'b0;
    underflow_d = 1'b0;
    sticky_d    = sticky_q;

    if (clr) begin
      count_d  = '0;
      sticky_d = 1'b0;
    end else if (load_en) begin
      count_d = (load_ext > max_ext) ? WIDTH'(MAX_VAL) : load;
    end else if (en && (step != '0)) begin
      if (!down) begin
        if (sum_ext <= max_ext) begin
          count_d = WIDTH'(sum_ext);
        end else begin
          // Crossing the top: fold back into 0..MAX_VAL or pin at MAX_VAL.
          count_d    = sat_mode ? WIDTH'(MAX_VAL)
                                : WIDTH'(sum_ext - (max_ext + EW'(1)));
          rollover_d = 1'b1;
          sticky_d   = 1'b1;
        end
      end else begin
        if (cnt_ext >= step_ext) begin
          count_d = WIDTH'(cnt_ext - step_ext);
        end else begin
          // count < step <= MAX_VAL, so the wrapped value fits in EW bits.
          count_d     = sat_mode ? '0
                                 : WIDTH'((max_ext + EW'(1) - step_ext) + cnt_ext);
          underflow_d = 1'b1;
          sticky_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q     <= '0;
      rollover_q  <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      rollover_q  <= rollover_d;
      underflow_q <= underflow_d;
      sticky_q    <= sticky_d;
    end
  end

`ifdef COUNTER_UD_MOD_CMP_EN
  logic cmp_hit_q, cmp_hit_d;

  // Only a real change of value can hit; a held count never re-triggers.
  assign cmp_hit_d = (count_d != count_q) && (count_d == cmp_val);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_hit_q <= 1'b0;
    end else begin
      cmp_hit_q <= cmp_hit_d;
    end
  end

  assign cmp_hit = cmp_hit_q;
`endif

  assign count      = count_q;
  assign rollover   = rollover_q;
  assign underflow  = underflow_q;
  assign ovf_sticky = sticky_q;
  assign at_max     = (count_q == WIDTH'(MAX_VAL));
  assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_counter_ud_mod.sv
// Self-checking bench for counter_ud_mod (WIDTH=4, MAX_VAL=9, STEP_W=3).
// An integer reference model tracks the counter; a negedge process compares
// every cycle, and directed sequences add literal expectations.

`timescale 1ns/1ps

module tb_counter_ud_mod;

  localparam int WIDTH   = 4;
  localparam int MAX_VAL = 9;
  localparam int STEP_W  = 3;

  logic              clk;
  logic              rstn;
  logic              clr;
  logic              load_en;
  logic [WIDTH-1:0]  load;
  logic              en;
  logic              down;
  logic [STEP_W-1:0] step;
  logic              sat_mode;
  logic [WIDTH-1:0]  count;
  logic              rollover;
  logic              underflow;
  logic              ovf_sticky;
  logic              at_max;
  logic              at_zero;
`ifdef COUNTER_UD_MOD_CMP_EN
  logic [WIDTH-1:0]  cmp_val;
  logic              cmp_hit;
`endif

  int total;
  int bad;

  counter_ud_mod #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAX_VAL),
    .STEP_W (STEP_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .load_en   (load_en),
    .load      (load),
    .en        (en),
    .down      (down),
    .step      (step),
    .sat_mode  (sat_mode),
`ifdef COUNTER_UD_MOD_CMP_EN
    .cmp_val   (cmp_val),
    .cmp_hit   (cmp_hit),
`endif
    .count     (count),
    .rollover  (rollover),
    .underflow (underflow),
    .ovf_sticky(ovf_sticky),
    .at_max    (at_max),
    .at_zero   (at_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) -------------
  int m_count;
  int m_roll;
  int m_unf;
  int m_sticky;
  int m_hit;

  always @(posedge clk or negedge rstn) begin
    int c, r, u, s, h, st;
    if (!rstn) begin
      m_count  <= 0;
      m_roll   <= 0;
      m_unf    <= 0;
      m_sticky <= 0;
      m_hit    <= 0;
    end else begin
      c = m_count; r = 0; u = 0; s = m_sticky; h = 0;
      st = int'(step);
      if (clr) begin
        c = 0; s = 0;
      end else if (load_en) begin
        c = (int'(load) > MAX_VAL) ? MAX_VAL : int'(load);
      end else if (en && st != 0) begin
        if (!down) begin
          if (m_count + st <= MAX_VAL) c = m_count + st;
          else begin
            c = sat_mode ? MAX_VAL : m_count + st - (MAX_VAL + 1);
            r = 1; s = 1;
          end
        end else begin
          if (m_count >= st) c = m_count - st;
          else begin
            c = sat_mode ? 0 : m_count + (MAX_VAL + 1) - st;
            u = 1; s = 1;
          end
        end
      end
`ifdef COUNTER_UD_MOD_CMP_EN
      h = (c != m_count && c == int'(cmp_val)) ? 1 : 0;
`endif
      m_count  <= c;
      m_roll   <= r;
      m_unf    <= u;
      m_sticky <= s;
      m_hit    <= h;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("mdl_count",     int'(count),      m_count);
    check("mdl_rollover",  int'(rollover),   m_roll);
    check("mdl_underflow", int'(underflow),  m_unf);
    check("mdl_sticky",    int'(ovf_sticky), m_sticky);
    check("mdl_at_max",    int'(at_max),     (m_count == MAX_VAL) ? 1 : 0);
    check("mdl_at_zero",   int'(at_zero),    (m_count == 0) ? 1 : 0);
    check("mdl_excl",      int'(rollover & underflow), 0);
`ifdef COUNTER_UD_MOD_CMP_EN
    check("mdl_cmp_hit",   int'(cmp_hit),    m_hit);
`endif
  end

  // One cycle of stimulus; returns #1 after the following negedge.
  task automatic cyc(input bit c, input bit le, input int lv, input bit e,
                     input bit d, input int s, input bit sm);
    clr      = c;
    load_en  = le;
    load     = WIDTH'(lv);
    en       = e;
    down     = d;
    step     = STEP_W'(s);
    sat_mode = sm;
    @(negedge clk);
    #1;
    $display("cyc clr=%0b ld=%0b/%0d en=%0b dn=%0b st=%0d sat=%0b -> count=%0d ro=%0b uf=%0b sticky=%0b",
             c, le, lv, e, d, s, sm, count, rollover, underflow, ovf_sticky);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn = 1'b0;
    clr = 0; load_en = 0; load = '0; en = 0; down = 0; step = '0; sat_mode = 0;
`ifdef COUNTER_UD_MOD_CMP_EN
    cmp_val = '0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_count",  int'(count), 0);
    check("rst_sticky", int'(ovf_sticky), 0);
    check("rst_at_zero", int'(at_zero), 1);
    rstn = 1'b1;

    // Wrap up: 8 + 3 -> 1 with rollover.
    cyc(0, 1, 8, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 3, 0);
    check("wrapup_count", int'(count), 1);
    check("wrapup_roll",  int'(rollover), 1);
    check("wrapup_stky",  int'(ovf_sticky), 1);
    idle();
    check("wrapup_pulse_end", int'(rollover), 0);
    check("wrapup_stky_hold", int'(ovf_sticky), 1);

    // Priority: clr beats load and en; then load clamps 15 -> 9.
    cyc(1, 1, 7, 1, 0, 1, 0);
    check("prio_count",  int'(count), 0);
    check("prio_stky",   int'(ovf_sticky), 0);
    cyc(0, 1, 15, 0, 0, 0, 0);
    check("clamp_count", int'(count), 9);
    check("clamp_atmax", int'(at_max), 1);

    // Saturate up at the bound pulses every time.
    cyc(0, 0, 0, 1, 0, 2, 1);
    check("satup_count", int'(count), 9);
    check("satup_roll",  int'(rollover), 1);
    cyc(0, 0, 0, 1, 0, 2, 1);
    check("satup_roll2", int'(rollover), 1);

    // Saturate down: 2 - 5 -> 0, twice.
    cyc(0, 1, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 5, 1);
    check("satdn_count", int'(count), 0);
    check("satdn_unf",   int'(underflow), 1);
    cyc(0, 0, 0, 1, 1, 5, 1);
    check("satdn_count2", int'(count), 0);
    check("satdn_unf2",   int'(underflow), 1);
    check("satdn_atzero", int'(at_zero), 1);

    // Wrap down: 1 - 4 -> 7.
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 4, 0);
    check("wrapdn_count", int'(count), 7);
    check("wrapdn_unf",   int'(underflow), 1);
    check("wrapdn_atzero", int'(at_zero), 0);

    // Step zero holds, no event.
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("step0_count", int'(count), 7);
    check("step0_roll",  int'(rollover), 0);
    check("step0_unf",   int'(underflow), 0);

    // Exact reach of MAX_VAL, then one past wraps to 0.
    cyc(0, 0, 0, 1, 0, 2, 0);
    check("exact_count", int'(count), 9);
    check("exact_roll",  int'(rollover), 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    check("edge_count",  int'(count), 0);
    check("edge_roll",   int'(rollover), 1);

    // Async reset between edges.
    cyc(0, 1, 6, 0, 0, 0, 0);
    check("pre_rst_count", int'(count), 6);
    clr = 0; load_en = 0; en = 1; down = 0; step = STEP_W'(1); sat_mode = 0;
    #2 rstn = 1'b0;
    #1;
    check("arst_count",  int'(count), 0);
    check("arst_sticky", int'(ovf_sticky), 0);
    check("arst_roll",   int'(rollover), 0);
    @(negedge clk);
    #1;
    check("arst_hold", int'(count), 0);
    rstn = 1'b1;
    cyc(0, 0, 0, 1, 0, 1, 0);
    check("post_rst_count", int'(count), 1);

`ifdef COUNTER_UD_MOD_CMP_EN
    cmp_val = WIDTH'(5);
    cyc(0, 1, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 2, 0);
    check("cmp_count", int'(count), 5);
    check("cmp_hit1",  int'(cmp_hit), 1);
    idle();
    check("cmp_hit0",  int'(cmp_hit), 0);
`endif

    // Mixed pseudo-random traffic; the model checks every cycle.
    for (int i = 0; i < 60; i++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
          $urandom_range(0, 1) == 1);
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_ud_mod.md
COUNTER_UD_MOD -- requirements
Module: counter_ud_mod

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal value; count range is 0..MAX_VAL; legal range 1..2**WIDTH-1.
REQ-003 Parameter STEP_W, default 4: step input width; 2**STEP_W-1 SHALL be <= MAX_VAL (elaboration check).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 clr  in  1  synchronous clear to 0.
REQ-007 load_en  in  1  load count from load.
REQ-008 load  in  WIDTH  load value.
REQ-009 en  in  1  count enable.
REQ-010 down  in  1  1 = count down, 0 = count up.
REQ-011 step  in  STEP_W  increment/decrement magnitude.
REQ-012 sat_mode  in  1  1 = saturate at bounds, 0 = modulo wrap.
REQ-013 count  out  WIDTH  registered counter value.
REQ-014 rollover  out  1  registered one-cycle pulse on an up-boundary crossing.
REQ-015 underflow  out  1  registered one-cycle pulse on a down-boundary crossing.
REQ-016 ovf_sticky  out  1  registered; set by any rollover/underflow event, held until clr or reset.
REQ-017 at_max / at_zero  out  1 each  combinational: count==MAX_VAL / count==0.

Function
REQ-018 Priority per cycle SHALL be clr > load_en > en; with none asserted, count holds and the pulses are 0.
REQ-019 clr SHALL set count=0, rollover=0, underflow=0, ovf_sticky=0 at the next edge.
REQ-020 load_en SHALL set count=min(load, MAX_VAL) at the next edge; pulses 0; ovf_sticky unchanged.
REQ-021 en with step==0 SHALL hold count and produce no event.
REQ-022 Arithmetic SHALL be done in WIDTH+1 bits; no intermediate truncation.
REQ-023 Up, count+step<=MAX_VAL: count<=count+step.
REQ-024 Up, count+step>MAX_VAL: wrap mode count<=count+step-(MAX_VAL+1); saturate mode count<=MAX_VAL; both: rollover=1 for one cycle, ovf_sticky<=1.
REQ-025 Down, count>=step: count<=count-step.
REQ-026 Down, count<step: wrap mode count<=count+(MAX_VAL+1)-step; saturate mode count<=0; both: underflow=1 for one cycle, ovf_sticky<=1.
REQ-027 In saturate mode at a bound, each further en step toward that bound SHALL pulse rollover/underflow again while count stays at the bound.
REQ-028 Latency: count, pulses and ovf_sticky SHALL all reflect a request at the same rising edge (1 cycle); rollover and underflow SHALL never be high together.
REQ-029 sat_mode, down and step SHALL be sampled only in cycles with en=1; changing them between cycles SHALL need no flush.

Reset
REQ-030 rstn low SHALL immediately force count=0, rollover=0, underflow=0, ovf_sticky=0 (cmp_hit=0 when present), regardless of clk.
REQ-031 Reset asserted mid-count SHALL discard the in-flight update; the first edge after deassertion SHALL act on the inputs of that cycle.

Configuration
REQ-032 Macro COUNTER_UD_MOD_CMP_EN defined: adds input cmp_val [WIDTH] and output cmp_hit [1], a registered one-cycle pulse asserted at the edge where count changes to a value equal to cmp_val by en, load_en or clr (not when count holds).
REQ-033 Macro undefined: cmp_val and cmp_hit SHALL be absent from the port list and no compare logic synthesised; all other behaviour identical.

Verification (WIDTH=4, MAX_VAL=9, STEP_W=3)
REQ-034 Wrap up: count=8, en, up, step=3, sat_mode=0 -> count=1, rollover pulse 1 cycle, ovf_sticky=1.
REQ-035 Saturate down: count=2, en, down, step=5, sat_mode=1 -> count=0, underflow pulse; a second identical cycle -> count=0, underflow pulses again.
REQ-036 Priority: clr=1, load_en=1 (load=7), en=1 together -> count=0, ovf_sticky=0; next cycle load_en only with load=15 -> count=9 (clamped).
REQ-037 Async reset: count=6, rstn low between clock edges -> count=0 and all flags 0 before the next edge; release, en up step=1 -> count=1.
REQ-038 Wrap down: count=1, en, down, step=4, sat_mode=0 -> count=7, underflow pulse; at_zero/at_max track count each cycle.
REQ-039 With COUNTER_UD_MOD_CMP_EN, cmp_val=5: count=3, en up step=2 -> count=5 with cmp_hit pulse; en=0 next cycle -> cmp_hit=0.
